mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-ported `memory_unit` between the CPU (port 0) and a secondary bus master (port 1: debug loader / DMA). It registers grants, muxes the granted master's address/write data/write enable onto the memory, and returns read data. Burst-limited ownership and round-robin tie-breaking keep either master from starving the other.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_burst_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Saturating ownership-length counter; at_limit flags the last allowed cycle of a burst.
module burst_counter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int unsigned CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between the CPU and an auxiliary master.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_next;
  logic       rr_last;
  logic       at_limit;
  logic       cnt_clr;
  logic       cnt_inc;

  burst_counter #(.MAX_BURST(MAX_BURST)) u_burst_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_last <= PORT_AUX;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        if (state_next == OWN0) rr_last <= PORT_CPU;
        if (state_next == OWN1) rr_last <= PORT_AUX;
      end
    end
  end

  // Owner keeps the bus until it releases or the other side has waited a full burst.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_next = (rr_last == PORT_AUX) ? OWN0 : OWN1;
        else if (req0)     state_next = OWN0;
        else if (req1)     state_next = OWN1;
      end
      OWN0: begin
        if (req0 && (!req1 || !at_limit)) state_next = OWN0;
        else if (req1)                    state_next = OWN1;
        else                              state_next = IDLE;
      end
      OWN1: begin
        if (req1 && (!req0 || !at_limit)) state_next = OWN1;
        else if (req0)                    state_next = OWN0;
        else                              state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt_clr = (state_next != state) && (state_next != IDLE);
  assign cnt_inc = (state_next == state) && (state != IDLE);

  assign gnt0  = (state == OWN0);
  assign gnt1  = (state == OWN1);
  assign rdata = mem_rdata;

  // Write strobe is gated by the owner's live req so a dropped request never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      OWN0: begin
        mem_we    = we0 & req0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      OWN1: begin
        mem_we    = we1 & req1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] tbmem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: combinational read, write on rising edge.
  assign mem_rdata = tbmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, mem_we} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: gnt0/gnt1/mem_we=%b required 000", i, {gnt0, gnt1, mem_we});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: gnt0/gnt1=%b required 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_single_master();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0001_0000; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_we} !== 3'b101 || mem_addr !== 32'h0001_0000 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: gnt/we=%b addr=%h wdata=%h required 101 00010000 deadbeef",
               {gnt0, gnt1, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    we0 = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_read: mem_we=%b rdata=%h required 0 deadbeef", mem_we, rdata);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL single_release: gnt0/gnt1=%b required 00", {gnt0, gnt1});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4 * MAX_BURST; i++) begin
      @(negedge clk);
      exp = ((i / MAX_BURST) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({gnt0, gnt1} !== exp) begin
        errors++;
        $display("FAIL contention cyc%0d: gnt0/gnt1=%b required %b", i, {gnt0, gnt1}, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_early_release();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0010; wdata0 = 32'h0000_00A5;
    req1 = 1'b1; addr1 = 32'h0000_0020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
        errors++;
        $display("FAIL early_own0 cyc%0d: gnt0/gnt1=%b required 10", i, {gnt0, gnt1});
      end
    end
    req0 = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL early_overlap: mem_we=%b gnt0=%b required 0 1", mem_we, gnt0);
    end
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || mem_addr !== 32'h0000_0020) begin
      errors++;
      $display("FAIL early_handoff: gnt0/gnt1=%b addr=%h required 01 00000020", {gnt0, gnt1}, mem_addr);
    end
  endtask

  task automatic test_round_robin();
    // Port 1 is the owner on entry.
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL rr_idle1: gnt0/gnt1=%b required 00", {gnt0, gnt1});
    end
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rr_after_port1: gnt0/gnt1=%b required 10", {gnt0, gnt1});
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL rr_idle2: gnt0/gnt1=%b required 00", {gnt0, gnt1});
    end
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL rr_after_port0: gnt0/gnt1=%b required 01", {gnt0, gnt1});
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({gnt1, mem_we} !== 2'b11) begin
      errors++;
      $display("FAIL async_pre: gnt1/mem_we=%b required 11", {gnt1, mem_we});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_we} !== 3'b000) begin
      errors++;
      $display("FAIL async_drop: gnt0/gnt1/mem_we=%b required 000", {gnt0, gnt1, mem_we});
    end
    @(negedge clk);
    checks++;
    if (tbmem[8'h40] !== 32'h0) begin
      errors++;
      $display("FAIL async_mem: mem[0x40]=%h required 00000000", tbmem[8'h40]);
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = '0;
    test_reset();
    test_single_master();
    test_contention();
    test_early_release();
    test_round_robin();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
